// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider with ready/valid handshakes on both sides.
// One quotient bit is resolved per clock; divide-by-zero short-circuits straight to DONE.
module seq_divider #(
  parameter int BITS = 22
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] rem_q, rem_d;
  logic [BITS-1:0] q_q, q_d;
  logic [BITS-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] quot_q, quot_d;
  logic [BITS-1:0] remo_q, remo_d;
  logic            dbz_q, dbz_d;

  logic [BITS:0]   shifted;
  logic [BITS:0]   trial;
  logic            no_borrow;
  logic [BITS-1:0] rem_step;
  logic [BITS-1:0] q_step;

  // One restoring step: the borrow bit of the BITS+1 wide subtract decides the quotient bit.
  always_comb begin
    shifted   = {rem_q, q_q[BITS-1]};
    trial     = shifted - {1'b0, dvs_q};
    no_borrow = ~trial[BITS];
    rem_step  = no_borrow ? trial[BITS-1:0] : shifted[BITS-1:0];
    q_step    = {q_q[BITS-2:0], no_borrow};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt_q == '0) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    rem_d  = rem_q;
    q_d    = q_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    remo_d = remo_q;
    dbz_d  = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            quot_d = '1;
            remo_d = dividend;
            dbz_d  = 1'b1;
          end else begin
            rem_d = '0;
            q_d   = dividend;
            dvs_d = divisor;
            cnt_d = CW'(BITS - 1);
          end
        end
      end
      CALC: begin
        rem_d = rem_step;
        q_d   = q_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quot_d = q_step;
          remo_d = rem_step;
          dbz_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    quotient    = quot_q;
    remainder   = remo_q;
    div_by_zero = dbz_q;
  end

endmodule
